// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, signed-aware flags, variable shifts
// and a WIDTH-cycle shift-add multiplier.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             op_err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_ADDC = 4'd10;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier;
    logic [SHW-1:0]       mul_cnt;

    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     b_eff;
    logic                 carry_in;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_err;

    assign shamt    = b[SHW-1:0];
    assign acc_next = mplier[0] ? acc + mcand : acc;

    // One shared adder serves ADD, SUB (a + ~b + 1) and ADDC.
    always_comb begin
        b_eff    = b;
        carry_in = 1'b0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_err  = 1'b0;
        if (op == OP_SUB) begin
            b_eff    = ~b;
            carry_in = 1'b1;
        end else if (op == OP_ADDC) begin
            carry_in = c_in;
        end
        sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
        case (op)
            OP_ADD, OP_SUB, OP_ADDC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SHL:  alu_res = a << shamt;
            OP_SHR:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            op_err    <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            mul_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            mcand   <= {{WIDTH{1'b0}}, a};
                            mplier  <= b;
                            acc     <= '0;
                            mul_cnt <= '0;
                            state   <= MUL;
                        end else begin
                            result    <= alu_res;
                            flag_c    <= alu_c;
                            flag_v    <= alu_v;
                            flag_z    <= (alu_res == '0);
                            flag_n    <= alu_res[WIDTH-1];
                            op_err    <= alu_err;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                // LSB-first: multiplicand walks left while the multiplier walks right.
                MUL: begin
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + SHW'(1);
                    if (mul_cnt == SHW'(WIDTH - 1)) begin
                        result    <= acc_next[WIDTH-1:0];
                        flag_c    <= |acc_next[2*WIDTH-1:WIDTH];
                        flag_v    <= 1'b0;
                        flag_z    <= (acc_next[WIDTH-1:0] == '0);
                        flag_n    <= acc_next[WIDTH-1];
                        op_err    <= 1'b0;
                        out_valid <= 1'b1;
                        mul_cnt   <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vectors with literal expectations plus random traffic
// scored against an arithmetic model of each opcode.
module tb_seq_alu;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic         flag_n;
    logic         op_err;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
        .op_err(op_err)
    );

    typedef struct {
        logic [W-1:0] res;
        bit           c;
        bit           v;
        bit           z;
        bit           n;
        bit           err;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_ready = 0;
    bit   forced_ready = 1;
    bit   prev_valid = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Downstream readiness: random when enabled, otherwise whatever the driver asks for.
    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = forced_ready;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference behaviour computed from integer arithmetic on the operand values.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic ci);
        exp_t e;
        int ua, ub, sa, sb, full, sv, sh;
        ua = int'(x);
        ub = int'(y);
        sa = (ua >= MOD / 2) ? ua - MOD : ua;
        sb = (ub >= MOD / 2) ? ub - MOD : ub;
        sh = ub % W;
        e.res = '0; e.c = 0; e.v = 0; e.err = 0; e.acc_cyc = 0;
        e.lat = 1;
        case (o)
            4'd0: begin
                full = ua + ub; e.res = W'(full % MOD); e.c = (full >= MOD);
                sv = sa + sb;   e.v = (sv < -MOD / 2) || (sv >= MOD / 2);
            end
            4'd1: begin
                full = ua - ub; e.res = W'((full + MOD) % MOD); e.c = (ua >= ub);
                sv = sa - sb;   e.v = (sv < -MOD / 2) || (sv >= MOD / 2);
            end
            4'd2:  e.res = x & y;
            4'd3:  e.res = x | y;
            4'd4:  e.res = x ^ y;
            4'd5:  e.res = (ua < ub) ? W'(1) : W'(0);
            4'd6:  e.res = W'((ua << sh) % MOD);
            4'd7:  e.res = W'(ua >> sh);
            4'd8:  e.res = W'((sa >>> sh) & (MOD - 1));
            4'd9: begin
                full = ua * ub; e.res = W'(full % MOD); e.c = (full >= MOD);
                e.lat = W + 1;
            end
            4'd10: begin
                full = ua + ub + int'(ci); e.res = W'(full % MOD); e.c = (full >= MOD);
                sv = sa + sb + int'(ci);   e.v = (sv < -MOD / 2) || (sv >= MOD / 2);
            end
            default: e.err = 1;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Scoreboard: every cycle a result is presented it must match the oldest accepted op.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q[0];
                checkOutput("sb_result", 32'(result), 32'(e.res));
                checkOutput("sb_flag_c", 32'(flag_c), 32'(e.c));
                checkOutput("sb_flag_v", 32'(flag_v), 32'(e.v));
                checkOutput("sb_flag_z", 32'(flag_z), 32'(e.z));
                checkOutput("sb_flag_n", 32'(flag_n), 32'(e.n));
                checkOutput("sb_op_err", 32'(op_err), 32'(e.err));
                checkOutput("sb_in_ready_low", 32'(in_ready), 32'd0);
                if (!prev_valid) checkOutput("sb_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                if (out_ready) void'(exp_q.pop_front());
            end
            prev_valid = out_valid && !out_ready;
        end else begin
            prev_valid = 0;
        end
    end

    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic ci);
        exp_t e;
        bit   accepted = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; op = o; a = x; b = y; c_in = ci;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(o, x, y, ci);
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                accepted = 1;
            end
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    endtask

    task automatic waitValid(input string name);
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) checkOutput({name, "_valid_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic runDirected(input string name, input logic [3:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic ci, input logic [W-1:0] er,
                               input logic [4:0] eflags);
        exp_t m;
        m = model(o, x, y, ci);
        checkOutput({name, "_model"}, 32'({m.res, m.c, m.v, m.z, m.n, m.err}), 32'({er, eflags}));
        applyStimulus(o, x, y, ci);
        waitValid(name);
        checkOutput({name, "_result"}, 32'(result), 32'(er));
        checkOutput({name, "_flags_cvzne"}, 32'({flag_c, flag_v, flag_z, flag_n, op_err}), 32'(eflags));
    endtask

    task automatic waitDrain();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 500) begin
            @(negedge clk);
            k++;
        end
        checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] held;
        int           seen;
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_flags", 32'({flag_c, flag_v, flag_z, flag_n, op_err}), 32'd0);
        #1 rst = 1'b0;

        // flags packed as {c, v, z, n, op_err}
        runDirected("add",   4'd0,  8'd95,  8'd14,  1'b0, 8'h6D, 5'b00000);
        runDirected("addc",  4'd10, 8'd95,  8'd14,  1'b1, 8'h6E, 5'b00000);
        runDirected("sub_neg", 4'd1, 8'd14, 8'd95,  1'b0, 8'hAF, 5'b00010);
        runDirected("sub_ovf", 4'd1, 8'h80, 8'h01,  1'b0, 8'h7F, 5'b11000);
        runDirected("sub_eq",  4'd1, 8'd5,  8'd5,   1'b0, 8'h00, 5'b10100);
        runDirected("add_ovf", 4'd0, 8'h7F, 8'h01,  1'b0, 8'h80, 5'b01010);
        runDirected("mul",   4'd9,  8'd13,  8'd11,  1'b0, 8'h8F, 5'b00010);
        runDirected("mul_hi", 4'd9, 8'h10,  8'h10,  1'b0, 8'h00, 5'b10100);
        runDirected("sra",   4'd8,  8'h90,  8'h0A,  1'b0, 8'hE4, 5'b00010);
        runDirected("shr",   4'd7,  8'h90,  8'h0A,  1'b0, 8'h24, 5'b00000);
        runDirected("shl",   4'd6,  8'h81,  8'hF9,  1'b0, 8'h02, 5'b00000);
        runDirected("sltu",  4'd5,  8'h01,  8'hFF,  1'b0, 8'h01, 5'b00000);
        runDirected("illegal", 4'hF, 8'hAA, 8'h55,  1'b1, 8'h00, 5'b00101);

        // Backpressure: result must hold while new requests are offered and ignored.
        forced_ready = 0;
        applyStimulus(4'd2, 8'hCA, 8'h5F, 1'b0);
        waitValid("bp");
        held = result;
        checkOutput("bp_result", 32'(held), 32'h4A);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_result", 32'(result), 32'(held));
            checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        forced_ready = 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_released_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_released_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of a multiply aborts it.
        applyStimulus(4'd9, 8'd13, 8'd11, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_mid_mul_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_mul_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("rst_no_spurious", 32'(seen), 32'd0);
        runDirected("add_after_rst", 4'd0, 8'd95, 8'd14, 1'b0, 8'h6D, 5'b00000);

        // Random traffic with random downstream stalls.
        rand_ready = 1;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] ro;
            ro = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) ro = 4'd9;
            applyStimulus(ro, W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        waitDrain();
        rand_ready = 0;
        forced_ready = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
